// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS main control unit and the ALU control decoder.
// Contents: state encodings, supported opcodes, ALU_op / ALUSrcB / PCSource codes,
//           the packed control word and an opcode-support helper.
package mips_ctl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EX   = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU_op codes, also decoded by the ALU control block
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-unit <-> datapath bundle: opcode/mem_ready toward the controller, controls back.
// master: the control unit (drives controls and debug state).
// slave:  the datapath/memory side (drives opcode and mem_ready).
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALU_op;
  logic [1:0] PCSource;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, ALU_op, PCSource, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, ALU_op, PCSource, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control_out_decode.sv
// Pure combinational state -> datapath control decoder (no state of its own).
// Ports: state, reset (forces all controls low), mem_ready (FETCH write strobes), opcode (illegal_op).
// Output: ctl, the packed control word.
module mips_ctl_out_decode
  import mips_ctl_pkg::*;
(
  input  state_t     state,
  input  logic       reset,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  output ctl_t       ctl
);

  always_comb begin
    ctl = '0;
    // Reset holds the FSM in FETCH, but FETCH decodes MemRead=1; gate everything
    // so nothing reaches the datapath while reset is high.
    if (!reset) begin
      unique case (state)
        FETCH: begin
          ctl.mem_read  = 1'b1;
          ctl.alu_src_b = SRCB_FOUR;
          ctl.alu_op    = ALU_ADD;
          ctl.pc_source = PCSRC_ALU;
          // IR and PC load only on the cycle the instruction word arrives
          ctl.ir_write  = mem_ready;
          ctl.pc_write  = mem_ready;
        end
        DECODE: begin
          ctl.alu_src_b  = SRCB_IMM_SH;   // branch target precompute
          ctl.alu_op     = ALU_ADD;
          ctl.illegal_op = !op_supported(opcode);
        end
        MEM_ADDR, ADDI_EX: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = SRCB_IMM;
          ctl.alu_op    = ALU_ADD;
        end
        MEM_READ: begin
          ctl.mem_read = 1'b1;
          ctl.i_or_d   = 1'b1;
        end
        MEM_WRITE: begin
          ctl.mem_write = 1'b1;
          ctl.i_or_d    = 1'b1;
        end
        MEM_WB: begin
          ctl.reg_write  = 1'b1;
          ctl.mem_to_reg = 1'b1;
        end
        EXECUTE: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = SRCB_B;
          ctl.alu_op    = ALU_FUNCT;
        end
        R_WB: begin
          ctl.reg_write = 1'b1;
          ctl.reg_dst   = 1'b1;
        end
        ADDI_WB: begin
          ctl.reg_write = 1'b1;
        end
        BRANCH: begin
          ctl.alu_src_a     = 1'b1;
          ctl.alu_op        = ALU_SUB;
          ctl.pc_write_cond = 1'b1;
          ctl.pc_source     = PCSRC_ALUOUT;
        end
        JUMP: begin
          ctl.pc_write  = 1'b1;
          ctl.pc_source = PCSRC_JUMP;
        end
        default: ctl = '0;
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: one instruction at a time, fetch..writeback.
// Ports: clk, reset (async, active-high), bus (master side: opcode/mem_ready in, controls out).
// Memory states stall on mem_ready (unless MEM_WAIT_EN=0); outputs decode the state register.
module mips_multicycle_control
  import mips_ctl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  mips_multicycle_control_if.master  bus
);

  state_t state_q;
  state_t state_d;
  logic   is_store_q;   // lw/sw choice captured in DECODE, opcode is ignored afterwards
  logic   mem_rdy;
  ctl_t   ctl;

  assign mem_rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:     if (mem_rdy) state_d = DECODE;
      DECODE: begin
        unique case (bus.opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
          default:      state_d = FETCH;
        endcase
      end
      MEM_ADDR:  state_d = is_store_q ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_rdy) state_d = MEM_WB;
      MEM_WRITE: if (mem_rdy) state_d = FETCH;
      EXECUTE:   state_d = R_WB;
      ADDI_EX:   state_d = ADDI_WB;
      MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP: state_d = FETCH;
      default:   state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) is_store_q <= (bus.opcode == OP_SW);
    end
  end

  mips_ctl_out_decode u_out_decode (
    .state     (state_q),
    .reset     (reset),
    .mem_ready (mem_rdy),
    .opcode    (bus.opcode),
    .ctl       (ctl)
  );

  assign bus.PCWrite     = ctl.pc_write;
  assign bus.PCWriteCond = ctl.pc_write_cond;
  assign bus.IorD        = ctl.i_or_d;
  assign bus.MemRead     = ctl.mem_read;
  assign bus.MemWrite    = ctl.mem_write;
  assign bus.MemtoReg    = ctl.mem_to_reg;
  assign bus.IRWrite     = ctl.ir_write;
  assign bus.RegWrite    = ctl.reg_write;
  assign bus.RegDst      = ctl.reg_dst;
  assign bus.ALUSrcA     = ctl.alu_src_a;
  assign bus.ALUSrcB     = ctl.alu_src_b;
  assign bus.ALU_op      = ctl.alu_op;
  assign bus.PCSource    = ctl.pc_source;
  assign bus.illegal_op  = ctl.illegal_op;
  assign bus.state       = state_q;

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle MIPS main control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback for one instruction at a time and drives every datapath enable and mux select. It is the producer end of the `ALU_op` interface: its 2-bit `ALU_op` output, together with the instruction funct field, feeds the ALU control decoder that selects the ALU operation. It sits between the instruction register opcode field and the multicycle datapath, and stalls on a memory-ready handshake.

## Interface
- `MEM_WAIT_EN`, default 1. When 1, memory states wait for `mem_ready`. When 0, `mem_ready` is treated as constant 1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: IR[31:26]. Valid from the `DECODE` state onward.
- `mem_ready` in 1: memory completed the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA` out 1 each: datapath controls.
- `ALUSrcB` out 2: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALU_op` out 2: 00 = add, 01 = subtract, 10 = use funct.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: high during `DECODE` when `opcode` is unsupported.
- `state` out 4: current state, for debug.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
- States and transitions:
  - `FETCH` → `DECODE` when `mem_ready`; otherwise hold.
  - `DECODE` → by opcode: lw/sw → `MEM_ADDR`; R → `EXECUTE`; beq → `BRANCH`; j → `JUMP`; addi → `ADDI_EX`; other → `FETCH`.
  - `MEM_ADDR` → `MEM_READ` (lw) or `MEM_WRITE` (sw).
  - `MEM_READ` → `MEM_WB` when `mem_ready`; otherwise hold.
  - `MEM_WRITE` → `FETCH` when `mem_ready`; otherwise hold.
  - `EXECUTE` → `R_WB`.
  - `ADDI_EX` → `ADDI_WB`.
  - `MEM_WB`, `R_WB`, `ADDI_WB`, `BRANCH`, `JUMP` → `FETCH`.
- Outputs per state. Any output not listed is 0.
  - `FETCH`: `MemRead`=1, `ALUSrcB`=01, `ALU_op`=00, `PCSource`=00. `IRWrite` and `PCWrite` equal `mem_ready`.
  - `DECODE`: `ALUSrcB`=11, `ALU_op`=00 (branch target precompute).
  - `MEM_ADDR` and `ADDI_EX`: `ALUSrcA`=1, `ALUSrcB`=10, `ALU_op`=00.
  - `MEM_READ`: `MemRead`=1, `IorD`=1.
  - `MEM_WRITE`: `MemWrite`=1, `IorD`=1.
  - `MEM_WB`: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0.
  - `EXECUTE`: `ALUSrcA`=1, `ALUSrcB`=00, `ALU_op`=10.
  - `R_WB`: `RegWrite`=1, `RegDst`=1.
  - `ADDI_WB`: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0.
  - `BRANCH`: `ALUSrcA`=1, `ALU_op`=01, `PCWriteCond`=1, `PCSource`=01.
  - `JUMP`: `PCWrite`=1, `PCSource`=10.
- `opcode` is sampled only in `DECODE`. A later change to `opcode` does not alter the current path.
- An illegal opcode writes no state: no `RegWrite`, `MemWrite` or `PCWrite` occurs.

## Timing
- Registered state only. All outputs are combinational decode of `state`, except `IRWrite`/`PCWrite` in `FETCH` (depend on `mem_ready`) and `illegal_op` (depends on `opcode`).
- Cycles per instruction with `mem_ready` held 1:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Each cycle with `mem_ready`=0 in `FETCH`, `MEM_READ` or `MEM_WRITE` adds one cycle. No enable pulses twice per access.
- Reset:
  - Assertion forces `state`=`FETCH` immediately, regardless of clock, including mid-instruction. An in-flight sw must not assert `MemWrite` after `reset` rises.
  - While `reset`=1, all 1-bit outputs and `illegal_op` are 0, and `ALUSrcB`/`ALU_op`/`PCSource` are 00.
  - On the first cycle after release, outputs show `FETCH` values.
- `mem_ready` arriving in a non-memory state is ignored.

## Structure
- Shared package `mips_ctl_pkg`:
  - 4-bit state encodings: `FETCH`=0, `DECODE`=1, `MEM_ADDR`=2, `MEM_READ`=3, `MEM_WB`=4, `MEM_WRITE`=5, `EXECUTE`=6, `R_WB`=7, `BRANCH`=8, `JUMP`=9, `ADDI_EX`=10, `ADDI_WB`=11.
  - Opcode constants.
  - `ALU_op` codes (00 add, 01 sub, 10 funct), shared with the ALU control decoder.
- One sub-module: `mips_ctl_out_decode`, a pure combinational state-to-controls decoder. The top level holds the state register and next-state logic.

## Test plan
- lw, `mem_ready`=1, opcode 100011: states 0→1→2→3→4→0 over 5 cycles. `MemtoReg`=1 and `RegWrite`=1 only in cycle 5.
- R-type 000000: `ALU_op`=10 exactly in `EXECUTE`. `RegDst`=1 with `RegWrite`=1 in `R_WB`. Back in `FETCH` after 4 cycles.
- beq 000100 → `ALU_op`=01, `PCWriteCond`=1, `PCSource`=01 in cycle 3. j 000010 → `PCWrite`=1, `PCSource`=10 in cycle 3.
- sw with `mem_ready` low for 3 cycles in `MEM_WRITE`: `MemWrite` held for 4 cycles, `IorD`=1, exactly one `FETCH` re-entry.
- Opcode 111111 → `illegal_op`=1 for one cycle in `DECODE`, then `FETCH`. No write enable asserted.
- `reset` asserted mid-`MEM_WRITE` between clock edges: `MemWrite` drops to 0 immediately, `state`=0. After release, `MemRead`=1 and `ALUSrcB`=01.
